conv_enc_framer: RTL and testbench

CONV_ENC_FRAMER -- requirements
Module: conv_enc_framer

---
 rtl/conv_pkg.sv | 42 ++++
 rtl/conv_branch.sv | 15 +
 rtl/conv_enc_framer.sv | 144 ++++++++++++++
 tb/tb_conv_enc_framer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, types and tap helper for the K=4 rate-1/2 convolutional code.
// The encoder, decoder BMU/ACS and their benches all import this package.
package conv_pkg;

    localparam int unsigned K          = 4;
    localparam int unsigned NUM_STATES = 8;
    localparam int unsigned TAIL_LEN   = 3;
    localparam int unsigned STATE_W    = K - 1;
    localparam int unsigned SYM_W      = 2;
    localparam int unsigned TCNT_W     = 2;

    // Tap vectors, MSB = current input u, then s0, s1, s2.
    localparam logic [K-1:0] G0 = 4'o17;
    localparam logic [K-1:0] G1 = 4'o15;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_TAIL = 1'b1
    } fsm_e;

    typedef logic [STATE_W-1:0] trellis_state_t;
    typedef logic [SYM_W-1:0]   sym_t;

    typedef struct packed {
        logic last;
        sym_t sym;
    } sym_beat_t;

    // Modulo-2 sum of the shift register contents selected by generator g.
    function automatic logic tap_parity(input logic [K-1:0] g,
                                        input logic u,
                                        input trellis_state_t s);
        logic [K-1:0] reg_v;
        reg_v        = '0;
        reg_v[K-1]   = u;
        for (int unsigned i = 0; i < STATE_W; i++) begin
            reg_v[K-2-i] = s[i];
        end
        return ^(reg_v & g);
    endfunction

endpackage

// File: rtl/conv_branch.sv
// Reference trellis branch: (state, u) -> (code symbol, next state).
// Purely combinational; sym[0] is the G0 output, sym[1] the G1 output.
module conv_branch
    import conv_pkg::*;
(
    input  trellis_state_t state,
    input  logic           u,
    output sym_t           sym,
    output trellis_state_t next_state
);

    assign sym        = {tap_parity(G1, u, state), tap_parity(G0, u, state)};
    assign next_state = {state[STATE_W-2:0], u};

endmodule

// File: rtl/conv_enc_framer.sv
// Framed rate-1/2 K=4 convolutional encoder with a single-register output stage
// and optional zero-tail termination after every frame.
module conv_enc_framer
    import conv_pkg::*;
#(
    parameter bit TAIL_EN = 1'b1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_last,
    output logic             busy
);

    fsm_e               fsm_q;
    fsm_e               fsm_d;
    logic [TCNT_W-1:0]  tcnt_q;
    logic [TCNT_W-1:0]  tcnt_d;

    trellis_state_t     enc_state_q;
    sym_beat_t          beat_q;
    logic               out_valid_q;
    logic               busy_q;

    logic               free_c;
    logic               load_c;
    logic               u_c;
    logic               last_c;
    logic               zero_state_c;

    sym_t               br_sym;
    trellis_state_t     br_next;

    conv_branch u_branch (
        .state      (enc_state_q),
        .u          (u_c),
        .sym        (br_sym),
        .next_state (br_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q  <= ST_DATA;
            tcnt_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            tcnt_q <= tcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        fsm_d  = fsm_q;
        tcnt_d = tcnt_q;
        case (fsm_q)
            ST_DATA: begin
                if (load_c && in_last && TAIL_EN) begin
                    fsm_d  = ST_TAIL;
                    tcnt_d = '0;
                end
            end
            ST_TAIL: begin
                if (load_c) begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                    if (last_c) begin
                        fsm_d  = ST_DATA;
                        tcnt_d = '0;
                    end
                end
            end
            default: begin
                fsm_d  = ST_DATA;
                tcnt_d = '0;
            end
        endcase
    end

    // FSM outputs: handshake and what to load into the output register
    always_comb begin
        free_c       = !out_valid_q || out_ready;
        in_ready     = 1'b0;
        load_c       = 1'b0;
        u_c          = 1'b0;
        last_c       = 1'b0;
        zero_state_c = 1'b0;
        case (fsm_q)
            ST_DATA: begin
                in_ready     = rst_n && free_c;
                load_c       = in_ready && in_valid;
                u_c          = in_bit;
                last_c       = in_last && !TAIL_EN;
                zero_state_c = in_last && !TAIL_EN;
            end
            ST_TAIL: begin
                load_c = rst_n && free_c;
                last_c = (tcnt_q == TCNT_W'(TAIL_LEN - 1));
            end
            default: begin
                load_c = 1'b0;
            end
        endcase
    end

    // Encoder shift register and output stage; truncated frames restart from zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enc_state_q <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (load_c) begin
            beat_q      <= '{last: last_c, sym: br_sym};
            out_valid_q <= 1'b1;
            enc_state_q <= zero_state_c ? trellis_state_t'(0) : br_next;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
            beat_q.last <= 1'b0;
        end
    end

    // Frame activity: a new first bit wins over the closing transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else if (load_c && (fsm_q == ST_DATA)) begin
            busy_q <= 1'b1;
        end else if (out_valid_q && out_ready && beat_q.last) begin
            busy_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = beat_q.sym;
    assign out_last  = beat_q.last;
    assign busy      = busy_q;

endmodule

// File: tb/tb_conv_enc_framer.sv
// Directed bench for conv_enc_framer: one tail-terminated instance and one
// truncated instance, with hand-derived symbol sequences.
module tb_conv_enc_framer;

    logic       clk;
    logic       rst_n;

    logic       in_valid1, in_ready1, in_bit1, in_last1;
    logic       out_valid1, out_ready1, out_last1, busy1;
    logic [1:0] out_sym1;

    logic       in_valid0, in_ready0, in_bit0, in_last0;
    logic       out_valid0, out_ready0, out_last0, busy0;
    logic [1:0] out_sym0;

    int n_cmp;
    int n_bad;

    conv_enc_framer #(.TAIL_EN(1'b1)) dut_tail (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_bit    (in_bit1),
        .in_last   (in_last1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_sym   (out_sym1),
        .out_last  (out_last1),
        .busy      (busy1)
    );

    conv_enc_framer #(.TAIL_EN(1'b0)) dut_trunc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_bit    (in_bit0),
        .in_last   (in_last0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out_sym   (out_sym0),
        .out_last  (out_last0),
        .busy      (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply out_ready, advance one clock, then check the registered output.
    task automatic step(input bit sel, input string tag, input logic rdy,
                        input logic ev, input logic [1:0] es, input logic el);
        if (sel) out_ready1 = rdy;
        else     out_ready0 = rdy;
        @(posedge clk);
        #1;
        if (sel) begin
            chk({tag, ".valid"}, out_valid1, ev);
            if (ev) begin
                chk({tag, ".sym"},  out_sym1,  es);
                chk({tag, ".last"}, out_last1, el);
            end
        end else begin
            chk({tag, ".valid"}, out_valid0, ev);
            if (ev) begin
                chk({tag, ".sym"},  out_sym0,  es);
                chk({tag, ".last"}, out_last0, el);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid1 = 1'b0; in_bit1 = 1'b0; in_last1 = 1'b0; out_ready1 = 1'b1;
        in_valid0 = 1'b0; in_bit0 = 1'b0; in_last0 = 1'b0; out_ready0 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid",    out_valid1, 1'b0);
        chk("rst.sym",      out_sym1,   2'b00);
        chk("rst.last",     out_last1,  1'b0);
        chk("rst.busy",     busy1,      1'b0);
        chk("rst.in_ready", in_ready1,  1'b0);
        chk("rst.in_ready0", in_ready0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst.released_ready", in_ready1, 1'b1);

        // Impulse: 11,11,01,11
        in_valid1 = 1'b1; in_bit1 = 1'b1; in_last1 = 1'b1;
        #1;
        chk("A.in_ready", in_ready1, 1'b1);
        step(1'b1, "A.s0", 1'b1, 1'b1, 2'b11, 1'b0);
        chk("A.busy", busy1, 1'b1);
        in_valid1 = 1'b0;
        #1;
        chk("A.tail_ready", in_ready1, 1'b0);
        step(1'b1, "A.s1", 1'b1, 1'b1, 2'b11, 1'b0);
        step(1'b1, "A.s2", 1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b1, "A.s3", 1'b1, 1'b1, 2'b11, 1'b1);
        chk("A.busy_last", busy1, 1'b1);
        chk("A.ready_back", in_ready1, 1'b1);
        step(1'b1, "A.idle", 1'b1, 1'b0, 2'b00, 1'b0);
        chk("A.busy_end", busy1, 1'b0);

        // Eight zero bits: eleven 00 symbols, last only on the eleventh
        for (int i = 0; i < 8; i++) begin
            in_valid1 = 1'b1; in_bit1 = 1'b0; in_last1 = (i == 7);
            step(1'b1, $sformatf("B.d%0d", i), 1'b1, 1'b1, 2'b00, 1'b0);
        end
        in_valid1 = 1'b0; in_last1 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step(1'b1, $sformatf("B.t%0d", j), 1'b1, 1'b1, 2'b00, (j == 2));
        end
        step(1'b1, "B.idle", 1'b1, 1'b0, 2'b00, 1'b0);

        // Backpressure with stray input during the tail
        in_valid1 = 1'b1; in_bit1 = 1'b1; in_last1 = 1'b1;
        step(1'b1, "C.s0",  1'b1, 1'b1, 2'b11, 1'b0);
        in_last1 = 1'b0;
        out_ready1 = 1'b0;
        #1;
        chk("C.tail_ready", in_ready1, 1'b0);
        step(1'b1, "C.h0a", 1'b0, 1'b1, 2'b11, 1'b0);
        step(1'b1, "C.h0b", 1'b0, 1'b1, 2'b11, 1'b0);
        step(1'b1, "C.t0",  1'b1, 1'b1, 2'b11, 1'b0);
        chk("C.tail_ready_free", in_ready1, 1'b0);
        step(1'b1, "C.h1a", 1'b0, 1'b1, 2'b11, 1'b0);
        step(1'b1, "C.h1b", 1'b0, 1'b1, 2'b11, 1'b0);
        step(1'b1, "C.t1",  1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b1, "C.h2a", 1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b1, "C.h2b", 1'b0, 1'b1, 2'b01, 1'b0);
        step(1'b1, "C.t2",  1'b1, 1'b1, 2'b11, 1'b1);
        in_valid1 = 1'b0; in_bit1 = 1'b0;
        step(1'b1, "C.h3",  1'b0, 1'b1, 2'b11, 1'b1);
        chk("C.busy_stall", busy1, 1'b1);
        step(1'b1, "C.idle", 1'b1, 1'b0, 2'b00, 1'b0);
        chk("C.busy_end", busy1, 1'b0);

        // Back-to-back impulse frames, no idle symbol between them
        in_valid1 = 1'b1; in_bit1 = 1'b1; in_last1 = 1'b1;
        step(1'b1, "D.a0", 1'b1, 1'b1, 2'b11, 1'b0);
        in_valid1 = 1'b0;
        step(1'b1, "D.a1", 1'b1, 1'b1, 2'b11, 1'b0);
        step(1'b1, "D.a2", 1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b1, "D.a3", 1'b1, 1'b1, 2'b11, 1'b1);
        in_valid1 = 1'b1;
        step(1'b1, "D.b0", 1'b1, 1'b1, 2'b11, 1'b0);
        chk("D.busy_hold", busy1, 1'b1);
        in_valid1 = 1'b0;
        step(1'b1, "D.b1", 1'b1, 1'b1, 2'b11, 1'b0);
        step(1'b1, "D.b2", 1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b1, "D.b3", 1'b1, 1'b1, 2'b11, 1'b1);
        step(1'b1, "D.idle", 1'b1, 1'b0, 2'b00, 1'b0);
        chk("D.busy_end", busy1, 1'b0);

        // Reset after the second tail symbol, then a clean impulse
        in_valid1 = 1'b1; in_bit1 = 1'b1; in_last1 = 1'b1;
        step(1'b1, "E.s0", 1'b1, 1'b1, 2'b11, 1'b0);
        in_valid1 = 1'b0;
        step(1'b1, "E.s1", 1'b1, 1'b1, 2'b11, 1'b0);
        step(1'b1, "E.s2", 1'b1, 1'b1, 2'b01, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("E.rst_ready", in_ready1, 1'b0);
        step(1'b1, "E.rst", 1'b1, 1'b0, 2'b00, 1'b0);
        chk("E.rst_busy", busy1, 1'b0);
        rst_n = 1'b1;
        in_valid1 = 1'b1;
        step(1'b1, "E.f0", 1'b1, 1'b1, 2'b11, 1'b0);
        in_valid1 = 1'b0;
        step(1'b1, "E.f1", 1'b1, 1'b1, 2'b11, 1'b0);
        step(1'b1, "E.f2", 1'b1, 1'b1, 2'b01, 1'b0);
        step(1'b1, "E.f3", 1'b1, 1'b1, 2'b11, 1'b1);
        step(1'b1, "E.idle", 1'b1, 1'b0, 2'b00, 1'b0);

        // Truncated termination: bits 1,0(last) -> 11,11; next frame from 000
        in_valid0 = 1'b1; in_bit0 = 1'b1; in_last0 = 1'b0;
        step(1'b0, "F.s0", 1'b1, 1'b1, 2'b11, 1'b0);
        in_bit0 = 1'b0; in_last0 = 1'b1;
        step(1'b0, "F.s1", 1'b1, 1'b1, 2'b11, 1'b1);
        in_valid0 = 1'b0;
        #1;
        chk("F.no_tail_ready", in_ready0, 1'b1);
        step(1'b0, "F.idle", 1'b1, 1'b0, 2'b00, 1'b0);
        chk("F.busy_end", busy0, 1'b0);
        in_valid0 = 1'b1; in_bit0 = 1'b1; in_last0 = 1'b1;
        step(1'b0, "F.n0", 1'b1, 1'b1, 2'b11, 1'b1);
        in_valid0 = 1'b0;
        step(1'b0, "F.n_idle", 1'b1, 1'b0, 2'b00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
